// File: rtl/bcp_implication_arbiter.sv
// Drives the shared assignment broadcast bus of the clause array: issues one solver decision,
// then keeps rebroadcasting round-robin selected implications until quiescent or in conflict.
//
// state    | meaning
// S_IDLE   | ready for a solver decision
// S_ISSUE  | broadcast strobe is high this cycle
// S_SETTLE | clause array is settling after a broadcast
// S_EVAL   | sample unit/conflict outputs and pick the next action
// S_DONE   | propagation finished without conflict (bcp_done_o pulse)
// S_CONFL  | conflict reported (conflict_o pulse)
module bcp_implication_arbiter #(
  parameter int MAX_VARIABLE_ID       = 4,
  parameter int VARIABLE_ENCODING_LEN = $clog2(MAX_VARIABLE_ID + 1),
  parameter int MAX_CLAUSE            = 16,
  parameter int CLAUSE_ID_LEN         = $clog2(MAX_CLAUSE),
  parameter int SETTLE_CYCLES         = 1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        decision_valid_i,
  output logic                                        decision_ready_o,
  input  logic [VARIABLE_ENCODING_LEN-1:0]            decision_variable_id_i,
  input  logic                                        decision_assignment_i,
  input  logic [MAX_CLAUSE-1:0]                       clause_unit_i,
  input  logic [MAX_CLAUSE-1:0]                       clause_conflict_i,
  input  logic [MAX_CLAUSE*VARIABLE_ENCODING_LEN-1:0] clause_impl_id_i,
  input  logic [MAX_CLAUSE-1:0]                       clause_impl_assign_i,
  output logic                                        update_assignment_o,
  output logic [VARIABLE_ENCODING_LEN-1:0]            variable_id_o,
  output logic                                        assignment_o,
  output logic                                        bcp_done_o,
  output logic                                        conflict_o,
  output logic [CLAUSE_ID_LEN-1:0]                    conflict_clause_id_o,
  output logic [VARIABLE_ENCODING_LEN:0]              implication_count_o
);

  localparam int VEL = VARIABLE_ENCODING_LEN;
  localparam int SW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_EVAL,
    S_DONE,
    S_CONFL
  } state_t;

  state_t                   state;
  logic [CLAUSE_ID_LEN-1:0] rr_ptr;
  logic [SW-1:0]            settle_cnt;

  logic [MAX_CLAUSE-1:0]    valid_unit;
  logic                     sel_found;
  logic [CLAUSE_ID_LEN-1:0] sel_idx;
  logic [VEL-1:0]           sel_id;
  logic                     sel_val;
  logic [CLAUSE_ID_LEN-1:0] rr_next;
  logic                     any_conflict;
  logic [CLAUSE_ID_LEN-1:0] conf_idx;

  // A unit whose implied id is 0 carries no variable and is never issued.
  always_comb begin
    valid_unit = '0;
    for (int k = 0; k < MAX_CLAUSE; k++) begin
      valid_unit[k] = clause_unit_i[k] & (|clause_impl_id_i[k*VEL +: VEL]);
    end
  end

  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_id    = '0;
    sel_val   = 1'b0;
    for (int i = 0; i < MAX_CLAUSE; i++) begin
      idx = (int'(rr_ptr) + i) % MAX_CLAUSE;
      if (!sel_found && valid_unit[idx]) begin
        sel_found = 1'b1;
        sel_idx   = CLAUSE_ID_LEN'(idx);
        sel_id    = clause_impl_id_i[idx*VEL +: VEL];
        sel_val   = clause_impl_assign_i[idx];
      end
    end
  end

  assign rr_next = (sel_idx == CLAUSE_ID_LEN'(MAX_CLAUSE - 1)) ? '0
                                                               : sel_idx + CLAUSE_ID_LEN'(1);

  always_comb begin
    any_conflict = |clause_conflict_i;
    conf_idx     = '0;
    for (int k = MAX_CLAUSE - 1; k >= 0; k--) begin
      if (clause_conflict_i[k]) conf_idx = CLAUSE_ID_LEN'(k);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state                <= S_IDLE;
      decision_ready_o     <= 1'b1;
      update_assignment_o  <= 1'b0;
      variable_id_o        <= '0;
      assignment_o         <= 1'b0;
      bcp_done_o           <= 1'b0;
      conflict_o           <= 1'b0;
      conflict_clause_id_o <= '0;
      implication_count_o  <= '0;
      rr_ptr               <= '0;
      settle_cnt           <= '0;
    end else begin
      update_assignment_o  <= 1'b0;
      bcp_done_o           <= 1'b0;
      conflict_o           <= 1'b0;
      conflict_clause_id_o <= '0;
      case (state)
        S_IDLE: begin
          if (decision_valid_i) begin
            variable_id_o       <= decision_variable_id_i;
            assignment_o        <= decision_assignment_i;
            implication_count_o <= '0;
            update_assignment_o <= 1'b1;
            decision_ready_o    <= 1'b0;
            state               <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          settle_cnt <= SW'(SETTLE_CYCLES - 1);
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == '0) state <= S_EVAL;
          else settle_cnt <= settle_cnt - SW'(1);
        end
        S_EVAL: begin
          if (any_conflict) begin
            conflict_o           <= 1'b1;
            conflict_clause_id_o <= conf_idx;
            state                <= S_CONFL;
          end else if (sel_found) begin
            variable_id_o       <= sel_id;
            assignment_o        <= sel_val;
            rr_ptr              <= rr_next;
            if (implication_count_o != '1)
              implication_count_o <= implication_count_o + (VEL+1)'(1);
            update_assignment_o <= 1'b1;
            state               <= S_ISSUE;
          end else begin
            bcp_done_o <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE, S_CONFL: begin
          decision_ready_o <= 1'b1;
          state            <= S_IDLE;
        end
        default: begin
          decision_ready_o <= 1'b1;
          state            <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcp_implication_arbiter.sv
// Scoreboard bench for bcp_implication_arbiter: expected broadcast/done/conflict events are queued
// with their cycle and matched against the DUT outputs on every sampled cycle.
module tb_bcp_implication_arbiter;

  localparam int VEL = 3;
  localparam int MC  = 16;

  logic            clk;
  logic            rst_n;
  logic            decision_valid;
  logic            decision_ready;
  logic [VEL-1:0]  decision_variable_id;
  logic            decision_assignment;
  logic [MC-1:0]   clause_unit;
  logic [MC-1:0]   clause_conflict;
  logic [MC*VEL-1:0] clause_impl_id;
  logic [MC-1:0]   clause_impl_assign;
  logic            update_assignment;
  logic [VEL-1:0]  variable_id;
  logic            assignment;
  logic            bcp_done;
  logic            conflict;
  logic [3:0]      conflict_clause_id;
  logic [VEL:0]    implication_count;

  bcp_implication_arbiter dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .decision_valid_i       (decision_valid),
    .decision_ready_o       (decision_ready),
    .decision_variable_id_i (decision_variable_id),
    .decision_assignment_i  (decision_assignment),
    .clause_unit_i          (clause_unit),
    .clause_conflict_i      (clause_conflict),
    .clause_impl_id_i       (clause_impl_id),
    .clause_impl_assign_i   (clause_impl_assign),
    .update_assignment_o    (update_assignment),
    .variable_id_o          (variable_id),
    .assignment_o           (assignment),
    .bcp_done_o             (bcp_done),
    .conflict_o             (conflict),
    .conflict_clause_id_o   (conflict_clause_id),
    .implication_count_o    (implication_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // kind: 1 = broadcast strobe, 2 = bcp_done, 3 = conflict
  typedef struct {
    int kind;
    int cyc;
    int id;
    int val;
    int cid;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  task automatic expect_ev(input int kind, input int at, input int id, input int val, input int cid);
    exp_t e;
    e.kind = kind; e.cyc = at; e.id = id; e.val = val; e.cid = cid;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    int nact;
    int okind;
    bit ok;
    @(posedge clk);
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      total++; bad++;
      $display("FAIL missed_event kind=%0d at cyc=%0d, not observed by cyc=%0d", e.kind, e.cyc, cyc);
    end
    nact = int'(update_assignment) + int'(bcp_done) + int'(conflict);
    if (nact > 0) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output cyc=%0d strobe=%b done=%b conflict=%b, required none",
                 cyc, update_assignment, bcp_done, conflict);
      end else begin
        e = sb.pop_front();
        ok = 1'b1;
        okind = update_assignment ? 1 : (bcp_done ? 2 : 3);
        if (nact !== 1) ok = 1'b0;
        if (okind !== e.kind || cyc !== e.cyc) ok = 1'b0;
        if (e.kind == 1 && (int'(variable_id) !== e.id || int'(assignment) !== e.val)) ok = 1'b0;
        if (e.kind == 3 && int'(conflict_clause_id) !== e.cid) ok = 1'b0;
        if (!ok) begin
          bad++;
          $display("FAIL event got kind=%0d n=%0d cyc=%0d id=%0d val=%0d cid=%0d required kind=%0d cyc=%0d id=%0d val=%0d cid=%0d",
                   okind, nact, cyc, variable_id, assignment, conflict_clause_id,
                   e.kind, e.cyc, e.id, e.val, e.cid);
        end
      end
    end
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 30) begin
      step();
      n++;
    end
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout pending=%0d required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic clear_clauses();
    clause_unit        = '0;
    clause_conflict    = '0;
    clause_impl_id     = '0;
    clause_impl_assign = '0;
  endtask

  task automatic set_unit(input int k, input int id, input int val);
    clause_unit[k]              = 1'b1;
    clause_impl_id[k*VEL +: VEL] = VEL'(id);
    clause_impl_assign[k]       = val[0];
  endtask

  task automatic do_decision(input int id, input int val, output int acc);
    int waited = 0;
    while (!decision_ready && waited < 50) begin
      step();
      waited++;
    end
    total++;
    if (decision_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_timeout got=%b required 1", decision_ready);
    end
    decision_variable_id = VEL'(id);
    decision_assignment  = val[0];
    decision_valid       = 1'b1;
    expect_ev(1, cyc + 1, id, val, 0);
    step();
    acc = cyc;
    decision_valid = 1'b0;
  endtask

  task automatic check_count(input string name, input int req);
    total++;
    if (int'(implication_count) !== req) begin
      bad++;
      $display("FAIL %s count got=%0d required %0d", name, implication_count, req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    decision_valid = 1'b1;
    decision_variable_id = 3'd3;
    decision_assignment = 1'b1;
    clear_clauses();
    repeat (3) step();
    total += 5;
    if (decision_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b required 1", decision_ready); end
    if (update_assignment !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b required 0", update_assignment); end
    if (bcp_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b required 0", bcp_done); end
    if (conflict !== 1'b0) begin bad++; $display("FAIL reset_conflict got=%b required 0", conflict); end
    if (implication_count !== '0) begin bad++; $display("FAIL reset_count got=%0d required 0", implication_count); end
    decision_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_clean_decision();
    int a;
    clear_clauses();
    do_decision(2, 1, a);
    expect_ev(2, a + 3, 0, 0, 0);
    drain();
    check_count("clean", 0);
  endtask

  task automatic test_single_implication();
    int a;
    clear_clauses();
    set_unit(1, 0, 1);  // id 0 unit must be skipped
    set_unit(3, 4, 0);
    do_decision(1, 1, a);
    expect_ev(1, a + 3, 4, 0, 0);
    step_to(a + 3);
    clear_clauses();
    expect_ev(2, a + 6, 0, 0, 0);
    drain();
    check_count("single_impl", 1);
  endtask

  task automatic test_round_robin();
    int a;
    // rr_ptr is 4 here; a unit at clause 4 moves it to 5
    clear_clauses();
    set_unit(4, 1, 1);
    do_decision(2, 0, a);
    expect_ev(1, a + 3, 1, 1, 0);
    step_to(a + 3);
    clear_clauses();
    expect_ev(2, a + 6, 0, 0, 0);
    drain();

    set_unit(2, 1, 1);
    set_unit(14, 2, 0);
    do_decision(3, 0, a);
    expect_ev(1, a + 3, 2, 0, 0);
    step_to(a + 3);
    clear_clauses();
    set_unit(15, 3, 1);
    expect_ev(1, a + 6, 3, 1, 0);
    step_to(a + 6);
    clear_clauses();
    set_unit(0, 4, 1);
    set_unit(15, 3, 0);
    expect_ev(1, a + 9, 4, 1, 0);
    step_to(a + 9);
    clear_clauses();
    expect_ev(2, a + 12, 0, 0, 0);
    drain();
    check_count("round_robin", 3);
  endtask

  task automatic test_conflict();
    int a;
    clear_clauses();
    set_unit(1, 2, 1);
    clause_conflict[6] = 1'b1;
    clause_conflict[9] = 1'b1;
    do_decision(4, 0, a);
    expect_ev(3, a + 3, 0, 0, 6);
    step_to(a + 4);
    clear_clauses();
    total++;
    if (decision_ready !== 1'b1) begin
      bad++;
      $display("FAIL conflict_ready got=%b required 1", decision_ready);
    end
    check_count("conflict", 0);
    drain();
  endtask

  task automatic test_reset_mid_settle();
    int a;
    clear_clauses();
    set_unit(5, 3, 0);
    do_decision(1, 1, a);
    expect_ev(1, a + 3, 3, 0, 0);
    step_to(a + 4);
    clear_clauses();
    check_count("pre_reset", 1);
    rst_n = 1'b0;
    step();
    total++;
    if (decision_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_ready got=%b required 1", decision_ready);
    end
    check_count("midreset", 0);
    step();
    rst_n = 1'b1;
    repeat (6) step();
    do_decision(4, 1, a);
    expect_ev(2, a + 3, 0, 0, 0);
    drain();
    check_count("after_reset", 0);
  endtask

  initial begin
    rst_n = 1'b0;
    decision_valid = 1'b0;
    decision_variable_id = '0;
    decision_assignment = 1'b0;
    clause_unit = '0;
    clause_conflict = '0;
    clause_impl_id = '0;
    clause_impl_assign = '0;
    test_reset();
    test_clean_decision();
    test_single_implication();
    test_round_robin();
    test_conflict();
    test_reset_mid_settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
